// File: rtl/contador_cascada.sv
// contador_cascada: extends an upstream 4-bit up/down/load counter with a
// HI_W-bit wrap counter driven by its ripple-carry. The output is {hi, q_prev}.
// The optional step checker is built only when CONTADOR_CASCADA_CHECK_EN is
// defined. It flags any upstream step that disagrees with the mode.
module contador_cascada #(
  parameter int unsigned HI_W = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [1:0]      modo,
  input  logic [3:0]      q_in,
  input  logic            rco_in,
  input  logic            clr_err,
  output logic [HI_W+3:0] cuenta,
  output logic            valid,
  output logic            ovf,
  output logic            err
);

  localparam int unsigned QW = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [HI_W-1:0] hi_q, hi_d;
  logic [QW-1:0]   q_prev_q, q_prev_d;
  logic [1:0]      modo_prev_q, modo_prev_d;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            err_q, err_d;

  logic [HI_W-1:0] hi_nx_c;
  logic            wrap_c;
  logic            step_bad_c;

  // Wrap-counter update implied by the current upstream mode and carry
  always_comb begin
    hi_nx_c = hi_q;
    wrap_c  = 1'b0;
    case (modo)
      2'd0: begin
        if (rco_in) begin
          hi_nx_c = hi_q + HI_W'(1);
          wrap_c  = &hi_q;
        end
      end
      2'd1, 2'd2: begin
        if (rco_in) begin
          hi_nx_c = hi_q - HI_W'(1);
          wrap_c  = (hi_q == '0);
        end
      end
      default: hi_nx_c = '0;
    endcase
  end

`ifdef CONTADOR_CASCADA_CHECK_EN
  logic [QW-1:0] exp_q_c;
  logic          exp_rco_c;

  // Expected upstream value and carry given the previous sample and mode
  always_comb begin
    exp_q_c   = q_prev_q;
    exp_rco_c = 1'b0;
    case (modo)
      2'd0: begin
        exp_q_c   = q_prev_q + QW'(1);
        exp_rco_c = (q_prev_q == '1);
      end
      2'd1: begin
        exp_q_c   = q_prev_q - QW'(1);
        exp_rco_c = (q_prev_q == '0);
      end
      2'd2: begin
        // Upstream down-by-3 wraps 0/1/2 to 12/13/14, not to mod-16 values
        exp_q_c   = (q_prev_q > QW'(2)) ? (q_prev_q - QW'(3)) : (q_prev_q + QW'(12));
        exp_rco_c = (q_prev_q < QW'(3));
      end
      default: begin
        exp_q_c   = q_prev_q;
        exp_rco_c = 1'b0;
      end
    endcase
    step_bad_c = ((modo != 2'd3) && (q_in != exp_q_c)) || (rco_in != exp_rco_c);
  end

  assign err = err_q;
`else
  assign step_bad_c = 1'b0;
  assign err        = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    hi_d        = hi_q;
    q_prev_d    = q_prev_q;
    modo_prev_d = modo_prev_q;
    valid_d     = valid_q;
    ovf_d       = 1'b0;
    err_d       = err_q;
    if (clr_err) begin
      state_d = IDLE;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else if (enable) begin
      q_prev_d    = q_in;
      modo_prev_d = modo;
      valid_d     = 1'b1;
      case (state_q)
        IDLE: begin
          state_d = TRACK;
        end
        TRACK, FAULT: begin
          hi_d  = hi_nx_c;
          ovf_d = wrap_c;
          // A mode change makes this cycle a resync, so it is not checked
          if ((state_q == TRACK) && (modo == modo_prev_q) && step_bad_c) begin
            err_d   = 1'b1;
            state_d = FAULT;
          end
        end
        default: begin
          state_d = IDLE;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      hi_q        <= '0;
      q_prev_q    <= '0;
      modo_prev_q <= '0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      q_prev_q    <= q_prev_d;
      modo_prev_q <= modo_prev_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
    end
  end

  assign cuenta = {hi_q, q_prev_q};
  assign valid  = valid_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_contador_cascada.sv
// Directed testbench for contador_cascada (HI_W = 8). Expectations follow the
// build: with CONTADOR_CASCADA_CHECK_EN defined, the error cases expect err=1.
module tb_contador_cascada;

`ifdef CONTADOR_CASCADA_CHECK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        enable;
  logic [1:0]  modo;
  logic [3:0]  q_in;
  logic        rco_in;
  logic        clr_err;
  logic [11:0] cuenta;
  logic        valid;
  logic        ovf;
  logic        err;

  int total;
  int bad;

  contador_cascada #(.HI_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .modo   (modo),
    .q_in   (q_in),
    .rco_in (rco_in),
    .clr_err(clr_err),
    .cuenta (cuenta),
    .valid  (valid),
    .ovf    (ovf),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the edge
  task automatic step(input logic en, input logic [1:0] m, input logic [3:0] q, input logic r);
    enable  = en;
    modo    = m;
    q_in    = q;
    rco_in  = r;
    clr_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    enable  = 1'b0;
    rco_in  = 1'b0;
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    enable  = 1'b0;
    modo    = 2'd0;
    q_in    = 4'd0;
    rco_in  = 1'b0;
    clr_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cuenta", 32'(cuenta), 32'h000);
    check("rst_valid", 32'(valid), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_err", 32'(err), 0);
    rst = 1'b0;

    // Count up 0..15 then wrap with carry
    step(1, 2'd0, 4'd0, 0);
    check("idle_capture_valid", 32'(valid), 1);
    check("idle_capture_cuenta", 32'(cuenta), 32'h000);
    for (int i = 1; i < 16; i++) step(1, 2'd0, 4'(i), 0);
    check("up_15_cuenta", 32'(cuenta), 32'h00F);
    step(1, 2'd0, 4'd0, 1);
    check("up_wrap_cuenta", 32'(cuenta), 32'h010);
    check("up_wrap_ovf", 32'(ovf), 0);
    check("up_wrap_err", 32'(err), 0);
    step(0, 2'd0, 4'd5, 1);
    check("disabled_hold", 32'(cuenta), 32'h010);

    // Walk hi down to 0 and then wrap to 255
    step(1, 2'd1, 4'd0, 0);
    check("m1_resync", 32'(cuenta), 32'h010);
    step(1, 2'd1, 4'd15, 1);
    check("m1_dec_to0", 32'(cuenta), 32'h00F);
    check("m1_dec_to0_ovf", 32'(ovf), 0);
    step(1, 2'd3, 4'd0, 0);
    check("load_cuenta", 32'(cuenta), 32'h000);
    step(1, 2'd1, 4'd0, 0);
    step(1, 2'd1, 4'd15, 1);
    check("dec_wrap_cuenta", 32'(cuenta), 32'hFFF);
    check("dec_wrap_ovf", 32'(ovf), 1);
    step(1, 2'd0, 4'd15, 0);
    check("ovf_one_cycle", 32'(ovf), 0);
    step(1, 2'd0, 4'd0, 1);
    check("inc_wrap_cuenta", 32'(cuenta), 32'h000);
    check("inc_wrap_ovf", 32'(ovf), 1);
    check("inc_wrap_err", 32'(err), 0);
    step(0, 2'd0, 4'd0, 0);
    check("ovf_disabled", 32'(ovf), 0);

    // Down-by-3: 5,2,14 legal, with the carry on 2->14
    step(1, 2'd2, 4'd5, 0);
    step(1, 2'd2, 4'd2, 0);
    step(1, 2'd2, 4'd14, 1);
    check("m2_good_cuenta", 32'(cuenta), 32'hFFE);
    check("m2_good_ovf", 32'(ovf), 1);
    check("m2_good_err", 32'(err), 0);
    step(1, 2'd2, 4'd11, 0);
    step(1, 2'd2, 4'd8, 0);
    step(1, 2'd2, 4'd5, 0);
    step(1, 2'd2, 4'd2, 0);
    check("m2_walk_err", 32'(err), 0);
    step(1, 2'd2, 4'd13, 1);
    check("m2_bad_err", 32'(err), 32'(CHK));
    check("m2_bad_valid", 32'(valid), 1);
    check("m2_bad_cuenta", 32'(cuenta), 32'hFED);
    clear();
    check("clr_err", 32'(err), 0);
    check("clr_valid", 32'(valid), 0);
    check("clr_hold_cuenta", 32'(cuenta), 32'hFED);

    // Up-step 3->5 is illegal; clear and recapture
    step(1, 2'd0, 4'd3, 0);
    check("recap_cuenta", 32'(cuenta), 32'hFE3);
    step(1, 2'd0, 4'd5, 0);
    check("skip_err", 32'(err), 32'(CHK));
    check("skip_cuenta", 32'(cuenta), 32'hFE5);
    clear();
    check("clr2_err", 32'(err), 0);
    check("clr2_valid", 32'(valid), 0);
    step(1, 2'd0, 4'd7, 0);
    check("recap2_valid", 32'(valid), 1);
    check("recap2_cuenta", 32'(cuenta), 32'hFE7);

    // Mode changes 0->3 (load 9) and 3->1 are unchecked resync cycles
    step(1, 2'd3, 4'd9, 0);
    check("load9_cuenta", 32'(cuenta), 32'h009);
    check("load9_err", 32'(err), 0);
    step(1, 2'd1, 4'd8, 0);
    check("m3to1_cuenta", 32'(cuenta), 32'h008);
    check("m3to1_err", 32'(err), 0);
    step(1, 2'd1, 4'd7, 0);
    check("m1_step_err", 32'(err), 0);

    // Pump hi to 7 with bad up-steps; err is set only when checking is built
    for (int i = 0; i < 7; i++) step(1, 2'd0, 4'd0, 1);
    check("pump_cuenta", 32'(cuenta), 32'h070);
    check("pump_err", 32'(err), 32'(CHK));

    // Asynchronous reset between edges
    enable = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_cuenta", 32'(cuenta), 32'h000);
    check("arst_valid", 32'(valid), 0);
    check("arst_err", 32'(err), 0);
    check("arst_ovf", 32'(ovf), 0);
    #2 rst = 1'b0;
    step(1, 2'd0, 4'd4, 1);
    check("post_rst_cuenta", 32'(cuenta), 32'h004);
    check("post_rst_valid", 32'(valid), 1);
    check("post_rst_ovf", 32'(ovf), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
